cnn_pool_relu: RTL and testbench

Streaming ReLU + 2x2/stride-2 max-pool stage directly downstream of the loop-tiled convolution layer. It accepts the convolution output feature map one signed pixel per beat in raster order, channel-major. It emits the pooled map in the same order over a valid/ready stream for the next layer. A half-row line buffer holds partial maxima, so no full-frame storage is needed.

---
 rtl/cnn_pool_relu.sv | 121 ++++++++++++
 tb/tb_cnn_pool_relu.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_pool_relu.sv
// Streaming ReLU + 2x2/stride-2 max-pool with a half-row line buffer.
// Define CNN_POOL_RELU_EN to clamp negative pixels to zero before pooling.
module cnn_pool_relu #(
  parameter int DATA_W = 8,
  parameter int FM_W   = 10,
  parameter int FM_H   = 10,
  parameter int CH     = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_last
);

  localparam int CW = (FM_W > 1) ? $clog2(FM_W) : 1;
  localparam int RW = (FM_H > 1) ? $clog2(FM_H) : 1;
  localparam int KW = (CH > 1) ? $clog2(CH) : 1;
  localparam int HN = FM_W / 2;
  localparam int HW = (HN > 1) ? $clog2(HN) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [KW-1:0] ch;

  logic signed [DATA_W-1:0] h_reg;
  logic signed [DATA_W-1:0] lbuf [HN];

  logic signed [DATA_W-1:0] p;
  logic signed [DATA_W-1:0] hmax;
  logic signed [DATA_W-1:0] lb_rd;
  logic signed [DATA_W-1:0] vmax;
  logic [HW-1:0]            hidx;

  logic beat;
  logic col_last;
  logic row_last;
  logic ch_last;
  logic emit;
  logic lb_wr;

  assign in_ready = !out_valid || out_ready;
  assign beat     = in_valid && in_ready;

  assign col_last = (col == CW'(FM_W - 1));
  assign row_last = (row == RW'(FM_H - 1));
  assign ch_last  = (ch == KW'(CH - 1));

`ifdef CNN_POOL_RELU_EN
  assign p = in_data[DATA_W-1] ? '0 : in_data;
`else
  assign p = in_data;
`endif

  assign hidx  = HW'(col >> 1);
  assign lb_rd = lbuf[hidx];
  assign hmax  = (p > h_reg) ? p : h_reg;
  assign vmax  = (hmax > lb_rd) ? hmax : lb_rd;

  // odd column closes a horizontal pair; odd row closes the window
  assign lb_wr = beat && col[0] && !row[0];
  assign emit  = beat && col[0] && row[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
      ch  <= '0;
    end else if (beat) begin
      if (!col_last) begin
        col <= col + 1'b1;
      end else begin
        col <= '0;
        if (!row_last) begin
          row <= row + 1'b1;
        end else begin
          row <= '0;
          ch  <= ch_last ? '0 : ch + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_reg <= '0;
    end else if (beat && !col[0]) begin
      h_reg <= p;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HN; i++) begin
        lbuf[i] <= '0;
      end
    end else if (lb_wr) begin
      lbuf[hidx] <= hmax;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data  <= vmax;
      out_last  <= ch_last && row_last && col_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cnn_pool_relu.sv
// Scoreboard bench for cnn_pool_relu: random/directed frames vs a
// window-max reference model built from a per-channel image array.
module tb_cnn_pool_relu;

  localparam int DW    = 8;
  localparam int FW    = 10;
  localparam int FH    = 10;
  localparam int NC    = 7;
  localparam int PER_F = NC * (FW / 2) * (FH / 2);
  localparam int FRAME = NC * FW * FH;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic                 out_last;

  cnn_pool_relu #(
    .DATA_W(DW),
    .FM_W  (FW),
    .FM_H  (FH),
    .CH    (NC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    bit last;
  } exp_t;

  exp_t sb[$];
  int   img [FH][FW];
  int   m_col, m_row, m_ch;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fail(string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired", nm);
  endtask

  function automatic int relu(int v);
`ifdef CNN_POOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int max4(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  task automatic model_reset();
    m_col = 0;
    m_row = 0;
    m_ch  = 0;
    sb.delete();
  endtask

  task automatic model_beat(int v);
    exp_t e;
    img[m_row][m_col] = relu(v);
    if (m_row % 2 == 1 && m_col % 2 == 1) begin
      e.data = max4(img[m_row-1][m_col-1], img[m_row-1][m_col],
                    img[m_row][m_col-1], img[m_row][m_col]);
      e.last = (m_ch == NC - 1) && (m_row == FH - 1) && (m_col == FW - 1);
      sb.push_back(e);
    end
    m_col++;
    if (m_col == FW) begin
      m_col = 0;
      m_row++;
      if (m_row == FH) begin
        m_row = 0;
        m_ch++;
        if (m_ch == NC) m_ch = 0;
      end
    end
  endtask

  // kind 0: random, 1: ramp on ch0, 2: negative windows on ch0
  function automatic int gen(int kind);
    logic signed [DW-1:0] b;
    b = DW'($urandom);
    if (kind == 1 && m_ch == 0) return (m_row * 10 + m_col) % 100;
    if (kind == 2 && m_ch == 0 && m_row < 2 && m_col < 4) begin
      case ({m_row[0], m_col[1:0]})
        3'b000: return -5;
        3'b001: return -3;
        3'b100: return -8;
        3'b101: return -1;
        3'b010: return -128;
        3'b011: return 127;
        3'b110: return 0;
        default: return 5;
      endcase
    end
    return int'(b);
  endfunction

  task automatic drive(int n, int kind, int vpct, int rpct,
                       bit hold_arm, bit stall_arm);
    int got = 0;
    int cyc = 0;
    int hold = 0;
    int stall = 0;
    bit have = 0;
    bit lat_pend = 0;
    bit harm = hold_arm;
    bit sarm = stall_arm;
    logic signed [DW-1:0] cur = '0;
    while (got < n) begin
      @(negedge clk);
      if (lat_pend) chk("latency", out_valid, 1);
      lat_pend = 0;
      cyc++;
      if (cyc > 20 * n + 200) begin
        fail("drive_timeout");
        break;
      end
      if (harm && out_valid) begin
        hold = 20;
        harm = 0;
      end
      if (hold > 0) begin
        out_ready = 1'b0;
        hold--;
      end else begin
        out_ready = ($urandom_range(0, 99) < rpct);
      end
      if (!have) begin
        cur  = DW'(gen(kind));
        have = 1;
      end
      if (sarm && m_row == 1 && m_col == 1) begin
        stall = 7;
        sarm  = 0;
      end
      if (stall > 0) begin
        in_valid = 1'b0;
        stall--;
      end else begin
        in_valid = ($urandom_range(0, 99) < vpct);
      end
      in_data = cur;
      #1;
      if (in_valid && in_ready) begin
        lat_pend = (m_row % 2 == 1) && (m_col % 2 == 1);
        model_beat(int'(cur));
        have = 0;
        got++;
      end
    end
  endtask

  initial begin : monitor
    bit held = 0;
    int fcnt = 0;
    int hd = 0;
    int hl = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        held = 0;
        fcnt = 0;
      end else begin
        chk("in_ready_rule", in_ready, int'(!out_valid || out_ready));
        if (held) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, hd);
          chk("hold_last", out_last, hl);
        end
        held = out_valid && !out_ready;
        hd   = out_data;
        hl   = out_last;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_last", out_last, int'(e.last));
          end
          n_out++;
          fcnt++;
          if (out_last) begin
            chk("frame_count", fcnt, PER_F);
            fcnt = 0;
          end
        end
      end
    end
  end

  initial begin : stim
    int w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    drive(2 * FRAME, 1, 100, 100, 0, 0);
    drive(FRAME, 2, 100, 100, 0, 0);
    drive(FRAME, 0, 100, 100, 1, 0);
    drive(FRAME, 0, 100, 100, 0, 1);
    drive(FRAME, 0, 60, 70, 0, 0);

    // stop right after pixel (ch2,row5,col3) with its result pending
    drive(2 * FW * FH + 5 * FW + 4, 0, 100, 100, 0, 0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("pending_before_rst", out_valid, 1);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_last", out_last, 0);
    @(negedge clk);
    rst = 1'b0;

    drive(FRAME, 0, 80, 80, 0, 0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    chk("total_outputs", n_out, 6 * PER_F + 61 + PER_F);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
